// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control slice.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } mc_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // M-stage match outranks W-stage match; callers already exclude x0.
    function automatic fwd_sel_e fwd_select(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_M;
        else if (hit_w) return FWD_W;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Pending-write scoreboard for the multi-cycle unit: one bit per architectural register.
module mc_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      set_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                      clr_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      rs1_busy_c,
    output logic                      rs2_busy_c,
    output logic                      rd_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear applied first so a same-register set in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
        rs1_busy_c = (rs1_addr_i != '0) && busy_q[rs1_addr_i];
        rs2_busy_c = (rs2_addr_i != '0) && busy_q[rs2_addr_i];
        rd_busy_c  = (rd_addr_i  != '0) && busy_q[rd_addr_i];
    end

endmodule

// File: rtl/pipeline_control_mc.sv
// Hazard/forwarding unit for the 5-stage RV32 core with scoreboarded
// variable-latency multi-cycle unit sharing the W-stage write port.
module pipeline_control_mc
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned LAT_WIDTH      = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_d_i,
    input  logic                      reg_write_d_i,
    input  logic                      mc_op_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_e_i,
    input  logic                      reg_write_e_i,
    input  logic [1:0]                result_src_e_i,
    input  logic                      mc_start_e_i,
    input  logic [LAT_WIDTH-1:0]      mc_latency_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
    input  logic                      reg_write_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_w_i,
    input  logic                      reg_write_w_i,
    input  logic                      pc_src_e_i,
    output logic                      stall_f_o,
    output logic                      stall_d_o,
    output logic                      flush_d_o,
    output logic                      flush_e_o,
    output logic [1:0]                forward_a_e_o,
    output logic [1:0]                forward_b_e_o,
    output logic                      mc_busy_o,
    output logic                      mc_wb_o,
    output logic                      mc_err_o
);

    mc_state_e                 state_q, state_d;
    logic [LAT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      err_q, err_d;
    logic [LAT_WIDTH-1:0]      lat_m1;
    logic                      sb_set, sb_clr;
    logic                      rs1_busy, rs2_busy, rd_busy;
    logic                      load_stall, sb_stall, struct_stall, stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Multi-cycle FSM: latency L gives the WB state L cycles after issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q | (mc_start_e_i && (state_q != IDLE));
        sb_set  = 1'b0;
        sb_clr  = 1'b0;
        mc_wb_o = 1'b0;
        lat_m1  = (mc_latency_e_i == '0) ? '0 : mc_latency_e_i - LAT_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (mc_start_e_i) begin
                    rd_d    = rd_addr_e_i;
                    cnt_d   = lat_m1;
                    sb_set  = (rd_addr_e_i != '0);
                    state_d = (lat_m1 == '0) ? WB : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q <= LAT_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - LAT_WIDTH'(1);
                end
            end
            WB: begin
                if (!reg_write_w_i) begin
                    mc_wb_o = 1'b1;
                    sb_clr  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mc_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (sb_set),
        .set_addr_i (rd_addr_e_i),
        .clr_i      (sb_clr),
        .clr_addr_i (rd_q),
        .rs1_addr_i (rs1_addr_d_i),
        .rs2_addr_i (rs2_addr_d_i),
        .rd_addr_i  (rd_addr_d_i),
        .rs1_busy_c (rs1_busy),
        .rs2_busy_c (rs2_busy),
        .rd_busy_c  (rd_busy)
    );

    // Hazard detection, forwarding selects; a taken branch overrides stalls.
    always_comb begin
        load_stall   = (result_src_e_i == RESULT_SRC_LOAD) && reg_write_e_i &&
                       (rd_addr_e_i != '0) &&
                       ((rd_addr_e_i == rs1_addr_d_i) || (rd_addr_e_i == rs2_addr_d_i));
        sb_stall     = rs1_busy || rs2_busy || (reg_write_d_i && rd_busy);
        struct_stall = mc_op_d_i && (state_q != IDLE);
        stall        = load_stall || sb_stall || struct_stall;

        stall_f_o = stall && !pc_src_e_i;
        stall_d_o = stall && !pc_src_e_i;
        flush_d_o = pc_src_e_i;
        flush_e_o = stall || pc_src_e_i;

        forward_a_e_o = fwd_select(
            reg_write_m_i && (rs1_addr_e_i != '0) && (rd_addr_m_i == rs1_addr_e_i),
            reg_write_w_i && (rs1_addr_e_i != '0) && (rd_addr_w_i == rs1_addr_e_i));
        forward_b_e_o = fwd_select(
            reg_write_m_i && (rs2_addr_e_i != '0) && (rd_addr_m_i == rs2_addr_e_i),
            reg_write_w_i && (rs2_addr_e_i != '0) && (rd_addr_w_i == rs2_addr_e_i));

        mc_busy_o = (state_q != IDLE);
        mc_err_o  = err_q;
    end

endmodule

// File: tb/tb_pipeline_control_mc.sv
// Self-checking bench for pipeline_control_mc: directed hazard scenarios plus
// randomized traffic compared against a cycle-indexed reference model.
module tb_pipeline_control_mc;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] rs1_addr_d_i, rs2_addr_d_i, rd_addr_d_i;
    logic       reg_write_d_i, mc_op_d_i;
    logic [4:0] rs1_addr_e_i, rs2_addr_e_i, rd_addr_e_i;
    logic       reg_write_e_i;
    logic [1:0] result_src_e_i;
    logic       mc_start_e_i;
    logic [5:0] mc_latency_e_i;
    logic [4:0] rd_addr_m_i, rd_addr_w_i;
    logic       reg_write_m_i, reg_write_w_i, pc_src_e_i;
    logic       stall_f_o, stall_d_o, flush_d_o, flush_e_o;
    logic [1:0] forward_a_e_o, forward_b_e_o;
    logic       mc_busy_o, mc_wb_o, mc_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an outstanding multi-cycle op is ready for writeback
    // from cycle m_ready onwards; m_sb holds registers with a pending result.
    bit m_active;
    int m_ready;
    int m_rd;
    bit m_err;
    bit m_sb[32];
    int cyc;

    pipeline_control_mc dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rs1_addr_d_i   (rs1_addr_d_i),
        .rs2_addr_d_i   (rs2_addr_d_i),
        .rd_addr_d_i    (rd_addr_d_i),
        .reg_write_d_i  (reg_write_d_i),
        .mc_op_d_i      (mc_op_d_i),
        .rs1_addr_e_i   (rs1_addr_e_i),
        .rs2_addr_e_i   (rs2_addr_e_i),
        .rd_addr_e_i    (rd_addr_e_i),
        .reg_write_e_i  (reg_write_e_i),
        .result_src_e_i (result_src_e_i),
        .mc_start_e_i   (mc_start_e_i),
        .mc_latency_e_i (mc_latency_e_i),
        .rd_addr_m_i    (rd_addr_m_i),
        .reg_write_m_i  (reg_write_m_i),
        .rd_addr_w_i    (rd_addr_w_i),
        .reg_write_w_i  (reg_write_w_i),
        .pc_src_e_i     (pc_src_e_i),
        .stall_f_o      (stall_f_o),
        .stall_d_o      (stall_d_o),
        .flush_d_o      (flush_d_o),
        .flush_e_o      (flush_e_o),
        .forward_a_e_o  (forward_a_e_o),
        .forward_b_e_o  (forward_b_e_o),
        .mc_busy_o      (mc_busy_o),
        .mc_wb_o        (mc_wb_o),
        .mc_err_o       (mc_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input int rs);
        if (rs != 0 && reg_write_m_i && int'(rd_addr_m_i) == rs) return 2'b10;
        if (rs != 0 && reg_write_w_i && int'(rd_addr_w_i) == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit pending(input int r);
        return (r != 0) && m_sb[r];
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_ready  = 0;
        m_rd     = 0;
        m_err    = 1'b0;
        foreach (m_sb[i]) m_sb[i] = 1'b0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check();
        bit ld, sb, st, stall, wb;
        ld = (result_src_e_i == 2'b01) && reg_write_e_i && (rd_addr_e_i != 0) &&
             (rd_addr_e_i == rs1_addr_d_i || rd_addr_e_i == rs2_addr_d_i);
        sb = pending(int'(rs1_addr_d_i)) || pending(int'(rs2_addr_d_i)) ||
             (reg_write_d_i && pending(int'(rd_addr_d_i)));
        st = mc_op_d_i && m_active;
        stall = ld || sb || st;
        wb = m_active && (cyc >= m_ready) && !reg_write_w_i && rst_ni;
        chk("stall_f", 8'(stall_f_o), 8'(stall && !pc_src_e_i));
        chk("stall_d", 8'(stall_d_o), 8'(stall && !pc_src_e_i));
        chk("flush_d", 8'(flush_d_o), 8'(pc_src_e_i));
        chk("flush_e", 8'(flush_e_o), 8'(stall || pc_src_e_i));
        chk("fwd_a",   8'(forward_a_e_o), 8'(fwd_exp(int'(rs1_addr_e_i))));
        chk("fwd_b",   8'(forward_b_e_o), 8'(fwd_exp(int'(rs2_addr_e_i))));
        chk("mc_busy", 8'(mc_busy_o), 8'(m_active));
        chk("mc_wb",   8'(mc_wb_o), 8'(wb));
        chk("mc_err",  8'(mc_err_o), 8'(m_err));
    endtask

    // Advance the model across one clock edge using the inputs held there.
    task automatic model_edge();
        bit fire;
        int lat;
        if (!rst_ni) return;
        fire = m_active && (cyc >= m_ready) && !reg_write_w_i;
        if (mc_start_e_i) begin
            if (m_active) begin
                m_err = 1'b1;
            end else begin
                lat      = (mc_latency_e_i == 0) ? 1 : int'(mc_latency_e_i);
                m_active = 1'b1;
                m_ready  = cyc + lat;
                m_rd     = int'(rd_addr_e_i);
                if (m_rd != 0) m_sb[m_rd] = 1'b1;
            end
        end
        if (fire) begin
            m_sb[m_rd] = 1'b0;
            m_active   = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        #1 check();
        @(posedge clk_i);
        model_edge();
    endtask

    task automatic drive_idle();
        rs1_addr_d_i = 0; rs2_addr_d_i = 0; rd_addr_d_i = 0;
        reg_write_d_i = 0; mc_op_d_i = 0;
        rs1_addr_e_i = 0; rs2_addr_e_i = 0; rd_addr_e_i = 0;
        reg_write_e_i = 0; result_src_e_i = 0;
        mc_start_e_i = 0; mc_latency_e_i = 0;
        rd_addr_m_i = 0; reg_write_m_i = 0;
        rd_addr_w_i = 0; reg_write_w_i = 0;
        pc_src_e_i = 0;
    endtask

    initial begin
        int n_st, n_wb;
        cyc = 0;
        model_reset();
        drive_idle();
        rst_ni = 1'b0;

        // Reset state with idle inputs
        repeat (2) @(negedge clk_i);
        step();
        chk("rst_busy", 8'(mc_busy_o), 8'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Forwarding priority and x0 exclusion
        @(negedge clk_i);
        rs1_addr_e_i = 5; rd_addr_m_i = 5; rd_addr_w_i = 5;
        reg_write_m_i = 1; reg_write_w_i = 1; rs2_addr_e_i = 5;
        #1 chk("fwd_prio", 8'(forward_a_e_o), 8'h2);
        step();
        @(negedge clk_i);
        rs1_addr_e_i = 0; rs2_addr_e_i = 0; rd_addr_m_i = 0; rd_addr_w_i = 0;
        #1 chk("fwd_x0", 8'(forward_a_e_o), 8'h0);
        step();
        @(negedge clk_i);
        rs2_addr_e_i = 6; rd_addr_w_i = 6; rd_addr_m_i = 4;
        step();

        // Load-use stall, then bubble, then rd=x0 load
        @(negedge clk_i);
        drive_idle();
        result_src_e_i = 2'b01; reg_write_e_i = 1; rd_addr_e_i = 7; rs2_addr_d_i = 7;
        #1 chk("load_stall", 8'(stall_d_o), 8'h1);
        step();
        @(negedge clk_i);
        drive_idle(); rs2_addr_d_i = 7;
        step();
        @(negedge clk_i);
        result_src_e_i = 2'b01; reg_write_e_i = 1; rd_addr_e_i = 0; rs2_addr_d_i = 0;
        #1 chk("load_x0", 8'(stall_f_o), 8'h0);
        step();

        // Multi-cycle RAW: rd=9, latency 4, rs1_d=9 held
        @(negedge clk_i);
        drive_idle();
        mc_start_e_i = 1; rd_addr_e_i = 9; mc_latency_e_i = 4; reg_write_e_i = 1;
        step();
        n_st = 0; n_wb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            drive_idle(); rs1_addr_d_i = 9;
            #1;
            if (stall_d_o) n_st++;
            if (mc_wb_o) begin
                n_wb++;
                chk("mc_wb_cycle", 8'(i), 8'd3);
            end
            step();
        end
        chk("raw_stalls", 8'(n_st), 8'd4);
        chk("raw_wb_count", 8'(n_wb), 8'd1);

        // Write-port conflict: latency 2, W port owned for 3 cycles
        @(negedge clk_i);
        drive_idle();
        mc_start_e_i = 1; rd_addr_e_i = 3; mc_latency_e_i = 2;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            drive_idle(); rs1_addr_d_i = 3;
            reg_write_w_i = (i < 3); rd_addr_w_i = 12;
            step();
        end

        // Branch overrides a load-use stall
        @(negedge clk_i);
        drive_idle();
        result_src_e_i = 2'b01; reg_write_e_i = 1; rd_addr_e_i = 7; rs1_addr_d_i = 7;
        pc_src_e_i = 1;
        #1 chk("br_stall_f", 8'(stall_f_o), 8'h0);
        chk("br_flush_e", 8'(flush_e_o), 8'h1);
        step();

        // Reset while BUSY discards the pending result
        @(negedge clk_i);
        drive_idle();
        mc_start_e_i = 1; rd_addr_e_i = 9; mc_latency_e_i = 10;
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            drive_idle(); rs1_addr_d_i = 9;
            step();
        end
        @(negedge clk_i);
        rst_ni = 1'b0; mc_op_d_i = 1;
        model_reset();
        #1 chk("rst_mid_stall", 8'(stall_d_o), 8'h0);
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        mc_op_d_i = 0;
        step();

        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            rs1_addr_d_i   = 5'($urandom_range(0, 7));
            rs2_addr_d_i   = 5'($urandom_range(0, 7));
            rd_addr_d_i    = 5'($urandom_range(0, 7));
            reg_write_d_i  = 1'($urandom_range(0, 1));
            mc_op_d_i      = ($urandom_range(0, 3) == 0);
            rs1_addr_e_i   = 5'($urandom_range(0, 7));
            rs2_addr_e_i   = 5'($urandom_range(0, 7));
            rd_addr_e_i    = 5'($urandom_range(0, 7));
            reg_write_e_i  = 1'($urandom_range(0, 1));
            result_src_e_i = 2'($urandom_range(0, 3));
            mc_start_e_i   = !m_active && ($urandom_range(0, 5) == 0);
            mc_latency_e_i = 6'($urandom_range(0, 6));
            rd_addr_m_i    = 5'($urandom_range(0, 7));
            reg_write_m_i  = 1'($urandom_range(0, 1));
            rd_addr_w_i    = 5'($urandom_range(0, 7));
            reg_write_w_i  = ($urandom_range(0, 2) == 0);
            pc_src_e_i     = ($urandom_range(0, 7) == 0);
            step();
        end

        // Start while not idle sets the sticky error and is ignored
        @(negedge clk_i);
        drive_idle();
        for (int i = 0; i < 12; i++) step();
        @(negedge clk_i);
        mc_start_e_i = 1; rd_addr_e_i = 4; mc_latency_e_i = 3;
        step();
        @(negedge clk_i);
        mc_start_e_i = 1; rd_addr_e_i = 5; mc_latency_e_i = 1;
        step();
        @(negedge clk_i);
        drive_idle(); rs1_addr_d_i = 5;
        #1 chk("err_sticky", 8'(mc_err_o), 8'h1);
        chk("err_no_sb", 8'(stall_d_o), 8'h0);
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
